// File: rtl/alu_divider_if.sv
// Operand, control and result bundle between the execute stage and the
// multicycle signed divider.
interface alu_divider_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_DIV,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_DIV,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/alu_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// with the signs applied in a final FIX cycle.
module alu_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic        clock,
    input logic        reset,
    alu_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] count;
    logic             sign_a, sign_b, div_zero, ovf;
    logic [WIDTH-1:0] mag_b, rem, quot;

    logic             start;
    logic [WIDTH:0]   a_ext, b_ext, mag_a_w, mag_b_w;
    logic [WIDTH:0]   rem_sh, diff;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;

    logic [WIDTH-1:0] fix_q, fix_r;
    logic             fix_e, load_out, rdy_next, busy_next;

    assign start = bus.ctrl_DIV;

    // One extra bit so that the magnitude of the most negative value fits.
    assign a_ext   = {bus.data_operandA[WIDTH-1], bus.data_operandA};
    assign b_ext   = {bus.data_operandB[WIDTH-1], bus.data_operandB};
    assign mag_a_w = a_ext[WIDTH] ? -a_ext : a_ext;
    assign mag_b_w = b_ext[WIDTH] ? -b_ext : b_ext;

    // rem_sh[WIDTH] set means the shifted remainder already exceeds any divisor.
    assign rem_sh   = {rem, quot[WIDTH-1]};
    assign diff     = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, mag_b};
    assign trial_ok = rem_sh[WIDTH] | ~diff[WIDTH];
    assign rem_next = trial_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = (bus.data_operandB == '0) ? FIX : RUN;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                RUN:     next_state = (count == CNT_W'(WIDTH - 1)) ? FIX : RUN;
                FIX:     next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        load_out  = (state == FIX);
        rdy_next  = (state == FIX);
        busy_next = (next_state == RUN) || (next_state == FIX);
        fix_q     = '0;
        fix_r     = '0;
        fix_e     = div_zero | ovf;
        if (!div_zero) begin
            fix_q = (sign_a ^ sign_b) ? -quot : quot;
            fix_r = sign_a ? -rem : rem;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            mag_b    <= '0;
            quot     <= '0;
            rem      <= '0;
            count    <= '0;
        end else if (start) begin
            sign_a   <= a_ext[WIDTH];
            sign_b   <= b_ext[WIDTH];
            div_zero <= (bus.data_operandB == '0);
            ovf      <= a_ext[WIDTH] && b_ext[WIDTH] &&
                        (mag_a_w == (WIDTH + 1)'(1 << (WIDTH - 1))) &&
                        (mag_b_w == (WIDTH + 1)'(1));
            mag_b    <= mag_b_w[WIDTH-1:0];
            quot     <= mag_a_w[WIDTH-1:0];
            rem      <= '0;
            count    <= '0;
        end else if (state == RUN) begin
            quot  <= {quot[WIDTH-2:0], trial_ok};
            rem   <= rem_next;
            count <= count + 1'b1;
        end
    end

    // Results hold across later operations until the next FIX edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.data_result    <= '0;
            bus.data_remainder <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= rdy_next;
            bus.busy           <= busy_next;
            if (load_out) begin
                bus.data_result    <= fix_q;
                bus.data_remainder <= fix_r;
                bus.data_exception <= fix_e;
            end
        end
    end
endmodule

// File: tb/tb_alu_divider.sv
// Directed and random checks of the signed divider against integer division.
module tb_alu_divider;
    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_q, last_r;
    logic       last_e;

    alu_divider_if #(.WIDTH(WIDTH)) bus ();

    alu_divider #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero, remainder
    // takes the dividend's sign.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic e);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = 8'h00; r = 8'h00; e = 1'b1;
        end else begin
            q = 8'(ia / ib);
            r = 8'(ia % ib);
            e = (ia == -128) && (ib == -1);
        end
    endfunction

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 8'($urandom);
        bus.data_operandB = 8'($urandom);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] a,
                                 input logic [7:0] b, input bit hold);
        logic [7:0] q, r;
        logic       e;
        int         lat;
        model(a, b, q, r, e);
        lat = (b == 8'h00) ? 1 : 9;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock);
            #1;
            if (k < lat) begin
                check({tag, " rdy_early"}, 8'(bus.data_resultRDY), 8'h00);
                check({tag, " busy"}, 8'(bus.busy), 8'h01);
                check({tag, " result_hold"}, bus.data_result, last_q);
            end else begin
                check({tag, " rdy"}, 8'(bus.data_resultRDY), 8'h01);
                check({tag, " busy_low"}, 8'(bus.busy), 8'h00);
                check({tag, " result"}, bus.data_result, q);
                check({tag, " remainder"}, bus.data_remainder, r);
                check({tag, " exception"}, 8'(bus.data_exception), 8'(e));
            end
        end
        last_q = q;
        last_r = r;
        last_e = e;
        if (hold) begin
            @(posedge clock);
            #1;
            check({tag, " rdy_fall"}, 8'(bus.data_resultRDY), 8'h00);
            check({tag, " result_kept"}, bus.data_result, q);
            check({tag, " rem_kept"}, bus.data_remainder, r);
            check({tag, " exc_kept"}, 8'(bus.data_exception), 8'(e));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " result"}, bus.data_result, 8'h00);
        check({tag, " remainder"}, bus.data_remainder, 8'h00);
        check({tag, " exception"}, 8'(bus.data_exception), 8'h00);
        check({tag, " rdy"}, 8'(bus.data_resultRDY), 8'h00);
        check({tag, " busy"}, 8'(bus.busy), 8'h00);
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit         seen_rdy;

        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 8'h00;
        bus.data_operandB = 8'h00;
        last_q = 8'h00; last_r = 8'h00; last_e = 1'b0;
        #2;
        check_cleared("reset");
        #20 reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic and sign cases
        start_op(8'h64, 8'h07);  expect_result("p100_p7", 8'h64, 8'h07, 1'b1);
        start_op(8'h9C, 8'h07);  expect_result("m100_p7", 8'h9C, 8'h07, 1'b1);
        start_op(8'h64, 8'hF9);  expect_result("p100_m7", 8'h64, 8'hF9, 1'b1);
        start_op(8'h9C, 8'hF9);  expect_result("m100_m7", 8'h9C, 8'hF9, 1'b1);

        // Divide by zero, overflow, most-negative by one
        start_op(8'h32, 8'h00);  expect_result("div0", 8'h32, 8'h00, 1'b1);
        start_op(8'h80, 8'hFF);  expect_result("ovf", 8'h80, 8'hFF, 1'b1);
        start_op(8'h80, 8'h01);  expect_result("min_by_one", 8'h80, 8'h01, 1'b1);

        // Restart while busy: 100/7 abandoned at E4 by 9/3
        start_op(8'h64, 8'h07);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock);
            #1;
            check("restart rdy_early", 8'(bus.data_resultRDY), 8'h00);
        end
        start_op(8'h09, 8'h03);
        expect_result("restart", 8'h09, 8'h03, 1'b1);

        // New start on the FIX edge: old result still delivered
        start_op(8'h1E, 8'h04);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            check("b2b rdy_early", 8'(bus.data_resultRDY), 8'h00);
        end
        bus.data_operandA = 8'h2D;
        bus.data_operandB = 8'hFA;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        bus.ctrl_DIV = 1'b0;
        check("b2b first_rdy", 8'(bus.data_resultRDY), 8'h01);
        check("b2b first_busy", 8'(bus.busy), 8'h01);
        check("b2b first_result", bus.data_result, 8'h07);
        check("b2b first_rem", bus.data_remainder, 8'h02);
        last_q = 8'h07; last_r = 8'h02; last_e = 1'b0;
        expect_result("b2b second", 8'h2D, 8'hFA, 1'b1);

        // Asynchronous reset between E5 and E6
        start_op(8'h64, 8'h07);
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_cleared("mid_reset");
        #2 reset = 1'b0;
        seen_rdy = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) seen_rdy = 1'b1;
        end
        check("mid_reset no_rdy", 8'(seen_rdy), 8'h00);
        check("mid_reset busy", 8'(bus.busy), 8'h00);
        last_q = 8'h00; last_r = 8'h00; last_e = 1'b0;
        start_op(8'h14, 8'h06);  expect_result("after_reset", 8'h14, 8'h06, 1'b1);

        // Random operands, with zero divisors and the overflow pair mixed in
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if (i % 8 == 7) begin
                ra = 8'h80;
                rb = 8'hFF;
            end
            start_op(ra, rb);
            expect_result("random", ra, rb, (i % 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
